seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL provide parameter DIV, default 50000, meaning CLK cycles per digit slot (1 kHz slot rate at 50 MHz); legal DIV >= 16, DIV a multiple of 8.
REQ-002 SHALL provide parameter NDIG, default 8, meaning number of multiplexed digits.
REQ-003 SHALL have port CLK  in  1  system clock, 50 MHz, rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port LOAD  in  1  one-cycle strobe; capture DATA/DP/BLANK.
REQ-006 SHALL have port DATA  in  4*NDIG  hex nibble per digit; nibble k drives digit k; digit 0 is rightmost.
REQ-007 SHALL have port DP  in  NDIG  decimal point per digit, 1 = lit.
REQ-008 SHALL have port BLANK  in  NDIG  per-digit blank, 1 = digit dark.
REQ-009 SHALL have port BRIGHT  in  3  brightness, 0 = dimmest, 7 = full.
REQ-010 SHALL have port nSEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port nDP  out  1  decimal point, active-low.
REQ-012 SHALL have port nDIG  out  NDIG  digit common select, active-low, one-hot-or-none.
REQ-013 SHALL have port FRAME  out  1  one-cycle pulse at each frame start (digit index wraps to 0).

Function
REQ-014 SHALL run slot counter cnt 0..DIV-1; tick when cnt == DIV-1; cnt wraps to 0 on tick.
REQ-015 SHALL advance digit index idx on tick: 0,1,...,NDIG-1,0; frame boundary = tick while idx == NDIG-1.
REQ-016 SHALL hold a pending buffer (DATA/DP/BLANK) and a display buffer; LOAD writes pending.
REQ-017 SHALL copy pending into display only at frame boundary, so a frame never mixes old and new data.
REQ-018 SHALL, when LOAD coincides with frame boundary, copy the LOAD-cycle DATA/DP/BLANK directly into display.
REQ-019 SHALL, for multiple LOADs within one frame, display only the last.
REQ-020 SHALL decode nibble per standard hex table: 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0010000, A->0001000, b->0000011, C->1000110, d->0100001, E->0000110, F->0001110.
REQ-021 SHALL assert nDIG[idx] low only while cnt < (BRIGHT+1)*(DIV/8) and BLANK[idx] of display buffer is 0; otherwise all nDIG high.
REQ-022 SHALL drive nSEG = 7'b1111111 and nDP = 1 whenever no digit is selected (no ghosting).
REQ-023 SHALL drive nDP = ~DP[idx] of display buffer while digit selected.
REQ-024 SHALL register all outputs; outputs reflect cnt/idx state with exactly one CLK latency.
REQ-025 SHALL pulse FRAME high for the one cycle following the frame-boundary tick.
REQ-026 SHALL sample BRIGHT continuously; a mid-slot change takes effect next cycle.

Reset
REQ-027 SHALL on RST clear cnt, idx, pending and display buffers to 0 (BLANK buffers to all 1).
REQ-028 SHALL on RST force nSEG = 7'b1111111, nDP = 1, nDIG all 1, FRAME = 0.
REQ-029 SHALL, after RST release, show nothing until first LOAD has passed a frame boundary.
REQ-030 SHALL, on RST mid-frame, abandon pending data and restart at idx 0, cnt 0.

Structure
REQ-031 SHALL place hex-to-segment table constants and blank pattern 7'b1111111 in the shared board package.
REQ-032 SHALL implement decode as sub-module seg7_dec (4-bit in, 7-bit active-low out, combinational).
REQ-033 SHALL implement scan timing, buffering and output registers in seg7_scan only.

Verification (DIV = 16, NDIG = 8)
REQ-034 SHALL check: RST released, no LOAD, 3 frames -> nDIG all 1, nSEG 7'b1111111, FRAME every 128 cycles.
REQ-035 SHALL check: LOAD DATA=32'h76543210, BLANK=0, BRIGHT=7 mid-frame -> old data finishes frame; next frame digit k shows pattern of k, nDIG[k] low 16 cycles each.
REQ-036 SHALL check: LOAD on frame-boundary cycle with DATA=32'hFEDCBA98 -> that frame shows F..8 immediately.
REQ-037 SHALL check: BRIGHT=0 -> each nDIG low exactly 2 of 16 slot cycles; BRIGHT=3 -> 8 cycles.
REQ-038 SHALL check: BLANK=8'h0F, DP=8'h80 -> digits 0-3 dark, nDP low only during digit 7.
REQ-039 SHALL check: RST asserted during digit 5 -> all outputs blank same edge; restart idx 0, previous data not displayed.

Source files
------------

// File: rtl/seg7_scan_pkg.sv
// Shared segment constants for the 7-segment display blocks.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_dec.sv
// Hex nibble to active-low segment pattern.
// Latency: combinational; no backpressure.
module seg7_dec
    import seg7_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_HEX[nib];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed NDIG-digit 7-segment scanner with frame-synchronous double buffering and PWM brightness.
// Latency: outputs registered, 1 cycle behind cnt/idx; no backpressure, LOAD always accepted.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int DIV  = 50000,
    parameter int NDIG = 8
)
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                LOAD,
    input  logic [4*NDIG-1:0]   DATA,
    input  logic [NDIG-1:0]     DP,
    input  logic [NDIG-1:0]     BLANK,
    input  logic [2:0]          BRIGHT,
    output logic [6:0]          nSEG,
    output logic                nDP,
    output logic [NDIG-1:0]     nDIG,
    output logic                FRAME
);

    localparam int CW    = $clog2(DIV);
    localparam int IW    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int SLOT8 = DIV / 8;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] pend_data_q, pend_data_d, disp_data_q, disp_data_d;
    logic [NDIG-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [NDIG-1:0]   pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
    logic [6:0]        nseg_q, nseg_d;
    logic              ndp_q, ndp_d;
    logic [NDIG-1:0]   ndig_q, ndig_d;
    logic              frame_q, frame_d;

    logic              tick;
    logic              frame_end;
    logic              lit;
    logic [31:0]       on_len;
    logic [3:0]        cur_nib;
    logic [6:0]        cur_seg;

    seg7_dec u_dec (
        .nib   (cur_nib),
        .seg_n (cur_seg)
    );

    always_comb begin
        tick      = (cnt_q == CW'(DIV - 1));
        frame_end = tick && (idx_q == IW'(NDIG - 1));

        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = frame_end ? '0 : idx_q + IW'(1);
        end

        pend_data_d  = LOAD ? DATA  : pend_data_q;
        pend_dp_d    = LOAD ? DP    : pend_dp_q;
        pend_blank_d = LOAD ? BLANK : pend_blank_q;

        // A LOAD on the boundary cycle bypasses pending so that frame starts with it.
        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
        if (frame_end) begin
            disp_data_d  = LOAD ? DATA  : pend_data_q;
            disp_dp_d    = LOAD ? DP    : pend_dp_q;
            disp_blank_d = LOAD ? BLANK : pend_blank_q;
        end

        on_len  = (32'(BRIGHT) + 32'd1) * 32'(SLOT8);
        lit     = (32'(cnt_q) < on_len) && !disp_blank_q[idx_q];
        cur_nib = disp_data_q[{idx_q, 2'b00} +: 4];

        ndig_d  = lit ? ~(NDIG'(1) << idx_q) : '1;
        nseg_d  = lit ? cur_seg : SEG_BLANK;
        ndp_d   = lit ? ~disp_dp_q[idx_q] : 1'b1;
        frame_d = frame_end;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '1;
            nseg_q       <= SEG_BLANK;
            ndp_q        <= 1'b1;
            ndig_q       <= '1;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            nseg_q       <= nseg_d;
            ndp_q        <= ndp_d;
            ndig_q       <= ndig_d;
            frame_q      <= frame_d;
        end
    end

    assign nSEG  = nseg_q;
    assign nDP   = ndp_q;
    assign nDIG  = ndig_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan at DIV=16, NDIG=8 (16-cycle slots, 128-cycle frames).
module tb_seg7_scan;

    localparam int DIV  = 16;
    localparam int NDIG = 8;
    localparam int FR   = DIV * NDIG;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LOAD = 1'b0;
    logic [31:0] DATA = '0;
    logic [7:0]  DP = '0;
    logic [7:0]  BLANK = '0;
    logic [2:0]  BRIGHT = 3'd7;
    logic [6:0]  nSEG;
    logic        nDP;
    logic [7:0]  nDIG;
    logic        FRAME;

    seg7_scan #(.DIV(DIV), .NDIG(NDIG)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .LOAD   (LOAD),
        .DATA   (DATA),
        .DP     (DP),
        .BLANK  (BLANK),
        .BRIGHT (BRIGHT),
        .nSEG   (nSEG),
        .nDP    (nDP),
        .nDIG   (nDIG),
        .FRAME  (FRAME)
    );

    always #5 CLK = ~CLK;

    logic [6:0] hex_exp [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int total = 0;
    int bad   = 0;

    logic [7:0] ndig_a  [FR];
    logic [6:0] nseg_a  [FR];
    logic       ndp_a   [FR];
    logic       frame_a [FR];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns on the negedge where FRAME is seen; counts lit samples before it.
    task automatic wait_frame(output int lit_cycles);
        lit_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (FRAME) return;
            if (nDIG != 8'hFF) lit_cycles++;
        end
        chk("frame_timeout", 32'(FRAME), 32'd1);
    endtask

    // Sample j shows slot idx=j/16, cnt=j%16; the last sample lands on the next FRAME.
    task automatic capture();
        for (int j = 0; j < FR; j++) begin
            @(negedge CLK);
            ndig_a[j]  = nDIG;
            nseg_a[j]  = nSEG;
            ndp_a[j]   = nDP;
            frame_a[j] = FRAME;
        end
    endtask

    function automatic int low_cnt(input int k);
        int n = 0;
        for (int j = 0; j < FR; j++) if (!ndig_a[j][k]) n++;
        return n;
    endfunction

    function automatic int late_lit(input int on);
        int n = 0;
        for (int j = 0; j < FR; j++) if (ndig_a[j] != 8'hFF && (j % DIV) >= on) n++;
        return n;
    endfunction

    task automatic check_digits(input string tag, input int on, input logic [7:0] blk, input logic [31:0] data);
        int wrong = 0;
        int ghost = 0;
        int early = 0;
        logic [3:0] nib;
        logic [7:0] sel;
        for (int j = 0; j < FR; j++) begin
            sel = ~(8'h01 << (j / DIV));
            if (ndig_a[j] != 8'hFF && ndig_a[j] != sel) wrong++;
            if (ndig_a[j] == 8'hFF && (nseg_a[j] != 7'h7F || ndp_a[j] != 1'b1)) ghost++;
            if (j < FR - 1 && frame_a[j]) early++;
        end
        for (int k = 0; k < NDIG; k++) begin
            chk($sformatf("%s_on%0d", tag, k), 32'(low_cnt(k)), blk[k] ? 32'd0 : 32'(on));
            if (!blk[k]) begin
                nib = data[k*4 +: 4];
                chk($sformatf("%s_seg%0d", tag, k), 32'(nseg_a[k*DIV]), 32'(hex_exp[nib]));
            end
        end
        chk({tag, "_wrongsel"}, 32'(wrong), 32'd0);
        chk({tag, "_ghost"}, 32'(ghost), 32'd0);
        chk({tag, "_late"}, 32'(late_lit(on)), 32'd0);
        chk({tag, "_frame_mid"}, 32'(early), 32'd0);
        chk({tag, "_frame_end"}, 32'(frame_a[FR-1]), 32'd1);
    endtask

    task automatic load_pulse(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] blk);
        DATA = d; DP = dp; BLANK = blk; LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0; DATA = 32'hDEADBEEF; DP = 8'h5A; BLANK = 8'hA5;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, last, nfr, gaps, lit, dp_lo, dp_out;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_nseg", 32'(nSEG), 32'h7F);
        chk("rst_ndp", 32'(nDP), 32'd1);
        chk("rst_ndig", 32'(nDIG), 32'hFF);
        chk("rst_frame", 32'(FRAME), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Idle: three dark frames, FRAME every 128 cycles.
        first = -1; last = -1; nfr = 0; gaps = 0; lit = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge CLK);
            if (nDIG != 8'hFF || nSEG != 7'h7F || nDP != 1'b1) lit++;
            if (FRAME) begin
                if (first < 0) first = c;
                else if (c - last != FR) gaps++;
                last = c;
                nfr++;
            end
        end
        chk("idle_first_frame", 32'(first), 32'd128);
        chk("idle_nframes", 32'(nfr), 32'd3);
        chk("idle_gaps", 32'(gaps), 32'd0);
        chk("idle_dark", 32'(lit), 32'd0);

        // Two mid-frame loads: old (dark) data finishes, then only the last one shows.
        BRIGHT = 3'd7;
        load_pulse(32'h11111111, 8'h00, 8'h00);
        repeat (3) @(negedge CLK);
        load_pulse(32'h76543210, 8'h00, 8'h00);
        wait_frame(lit);
        chk("old_frame_dark", 32'(lit), 32'd0);
        capture();
        check_digits("hex", 16, 8'h00, 32'h76543210);
        dp_lo = 0;
        for (int j = 0; j < FR; j++) if (!ndp_a[j]) dp_lo++;
        chk("hex_dp_dark", 32'(dp_lo), 32'd0);

        // Load on the boundary cycle itself: shows in the very next frame.
        repeat (FR - 1) @(negedge CLK);
        load_pulse(32'hFEDCBA98, 8'h00, 8'h00);
        chk("bnd_frame", 32'(FRAME), 32'd1);
        capture();
        check_digits("bnd", 16, 8'h00, 32'hFEDCBA98);

        BRIGHT = 3'd0;
        capture();
        check_digits("dim0", 2, 8'h00, 32'hFEDCBA98);
        BRIGHT = 3'd3;
        capture();
        check_digits("dim3", 8, 8'h00, 32'hFEDCBA98);

        // Per-digit blank and decimal point.
        BRIGHT = 3'd7;
        repeat (10) @(negedge CLK);
        load_pulse(32'h76543210, 8'h80, 8'h0F);
        wait_frame(lit);
        capture();
        check_digits("blk", 16, 8'h0F, 32'h76543210);
        dp_lo = 0; dp_out = 0;
        for (int j = 0; j < FR; j++) begin
            if (!ndp_a[j]) begin
                dp_lo++;
                if (j / DIV != 7) dp_out++;
            end
        end
        chk("blk_dp_count", 32'(dp_lo), 32'd16);
        chk("blk_dp_outside7", 32'(dp_out), 32'd0);

        // Reset while digit 5 is lit, with fresh data pending.
        repeat (84) @(negedge CLK);
        chk("pre_rst_digit5", 32'(nDIG), 32'hDF);
        load_pulse(32'h01234567, 8'hFF, 8'h00);
        #2 RST = 1'b1;
        #1;
        chk("arst_nseg", 32'(nSEG), 32'h7F);
        chk("arst_ndp", 32'(nDP), 32'd1);
        chk("arst_ndig", 32'(nDIG), 32'hFF);
        chk("arst_frame", 32'(FRAME), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        first = -1; lit = 0;
        for (int c = 1; c <= 300 && first < 0; c++) begin
            @(negedge CLK);
            if (nDIG != 8'hFF || nSEG != 7'h7F) lit++;
            if (FRAME) first = c;
        end
        chk("rst_restart_frame", 32'(first), 32'd128);
        chk("rst_no_old_data", 32'(lit), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
